// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and types for the SRAM port arbiter.
// Optional statistics are enabled elsewhere with SRAM_ARB_STATS_EN.
package sram_arb_pkg;

    localparam int MAX_REQ     = 8;
    localparam int IDX_MAX_W   = $clog2(MAX_REQ);
    localparam int TAG_W       = 1 + IDX_MAX_W;
    localparam int SRAM_RD_LAT = 2;

    // Read-return tag: valid bit plus the issuing requester index.
    typedef struct packed {
        logic                 vld;
        logic [IDX_MAX_W-1:0] idx;
    } tag_t;

    // Build a valid tag for requester idx.
    function automatic tag_t make_tag(input logic [IDX_MAX_W-1:0] idx);
        tag_t t;
        t.vld = 1'b1;
        t.idx = idx;
        return t;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side command/response bundle of the SRAM port arbiter.
// Requester i occupies slice i of every packed vector.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int WL_ADDR = 8,
    parameter int WL_DATA = 32
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_we;
    logic [NUM_REQ*WL_ADDR-1:0] req_addr;
    logic [NUM_REQ*WL_DATA-1:0] req_wdata;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [WL_DATA-1:0]         rsp_data;

    // Requesters drive commands and consume grants/responses.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    // The arbiter consumes commands and drives grants/responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after
// ptr (wrapping) wins.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    // Scan from the farthest offset down so the nearest requester to ptr wins last.
    always_comb begin
        int idx;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one single-port synchronous SRAM among NUM_REQ
// requesters, with a registered command stage and a 2-cycle read return.
// Define SRAM_ARB_STATS_EN to add busy/conflict counters.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WL_ADDR = 8,
    parameter int WL_DATA = 32
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus,
    output logic [WL_ADDR-1:0] sram_addr,
    output logic [WL_DATA-1:0] sram_wdata,
    output logic               sram_ena,
    input  logic [WL_DATA-1:0] sram_rdata
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]        stat_busy_cnt,
    output logic [31:0]        stat_conflict_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [WL_ADDR-1:0] r_sram_addr;
    logic [WL_DATA-1:0] r_sram_wdata;
    logic               r_sram_ena;
    tag_t               r_tag1;
    tag_t               r_tag2;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_hs;
    logic               w_hs_we;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req     (bus.req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Grants are suppressed during reset so nothing is accepted in that cycle.
    assign bus.req_ready = rst ? '0 : w_gnt;
    assign w_hs          = |(bus.req_valid & bus.req_ready);
    assign w_hs_we       = bus.req_we[w_gnt_idx];

    // Pointer, command register and tag pipe.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_rr_ptr     <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_sram_ena   <= 1'b0;
            r_tag1       <= '0;
            r_tag2       <= '0;
        end else begin
            r_sram_ena <= w_hs & w_hs_we;
            r_tag1     <= (w_hs && !w_hs_we) ? make_tag(IDX_MAX_W'(w_gnt_idx)) : '0;
            r_tag2     <= r_tag1;
            if (w_hs) begin
                r_rr_ptr     <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
                r_sram_addr  <= bus.req_addr[w_gnt_idx*WL_ADDR +: WL_ADDR];
                r_sram_wdata <= bus.req_wdata[w_gnt_idx*WL_DATA +: WL_DATA];
            end
        end
    end

    // One-hot decode of the returning tag.
    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = r_tag2.vld && (r_tag2.idx == IDX_MAX_W'(i));
        end
    end

    assign bus.rsp_data = sram_rdata;
    assign sram_addr    = r_sram_addr;
    assign sram_wdata   = r_sram_wdata;
    assign sram_ena     = r_sram_ena;

`ifdef SRAM_ARB_STATS_EN
    logic [31:0] r_busy_cnt;
    logic [31:0] r_conflict_cnt;

    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cnt     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_hs && r_busy_cnt != '1) r_busy_cnt <= r_busy_cnt + 32'd1;
            if ($countones(bus.req_valid) > 1 && r_conflict_cnt != '1)
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign stat_busy_cnt     = r_busy_cnt;
    assign stat_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM instance (1-cycle registered read, write-enable `ena`, old-data read-during-write) among `NUM_REQ` requesters such as the DMA loader, the conv feature-map reader and the result writer. It accepts valid/ready commands, picks one per cycle by round-robin, drives a registered command stage into the SRAM, and routes read data back to the issuing requester with a fixed latency. It sits between the layer datapath engines and each on-chip buffer SRAM.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `WL_ADDR`, 8: SRAM address width.
- `WL_DATA`, 32: SRAM data width.

Ports (vectors are packed, requester i at slice i):
- `clk`  in  1  main clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `req_valid`  in  NUM_REQ  command valid per requester.
- `req_ready`  out  NUM_REQ  command accepted this cycle (one-hot or zero).
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*WL_ADDR  command address.
- `req_wdata`  in  NUM_REQ*WL_DATA  write data.
- `rsp_valid`  out  NUM_REQ  read data valid, one-hot or zero, no backpressure.
- `rsp_data`  out  WL_DATA  read data, shared by all requesters, qualified by `rsp_valid`.
- `sram_addr`  out  WL_ADDR  to SRAM `addr`.
- `sram_wdata`  out  WL_DATA  to SRAM `wdata`.
- `sram_ena`  out  1  to SRAM `ena` (write strobe).
- `sram_rdata`  in  WL_DATA  from SRAM `rdata`.

## Operation
- Arbitration: combinational round-robin over `req_valid`, starting at pointer `rr_ptr`. `req_ready[g]` = 1 for the winner only. A handshake happens when `req_valid[g] & req_ready[g]`.
- After any handshake, `rr_ptr` is set to g+1 mod NUM_REQ. With no handshake, `rr_ptr` holds. Reset value of `rr_ptr` is 0, so requester 0 has first priority.
- Command stage (registered): on a handshake, `sram_addr`/`sram_wdata` load the winner's fields and `sram_ena` loads `req_we`. With no handshake, `sram_ena` goes to 0 and `sram_addr`/`sram_wdata` hold their values.
- A read handshake loads the tag pipe `tag1 = {1, g}`. With no read handshake, `tag1` loads 0. `tag2` loads `tag1` every cycle.
- `rsp_valid` is the one-hot decode of `tag2`, gated by its valid bit. `rsp_data` is `sram_rdata` passed through combinationally.
- Throughput: one command per cycle with no bubbles. A requester with `req_valid` held waits at most NUM_REQ-1 cycles.
- Ordering: all commands commit in acceptance order. A read accepted one cycle after a write to the same address returns the new data.
- A write produces no response.
- If `req_valid` drops while ready was low, nothing is latched (no request memory).
- Integration: the SRAM instance's active-low reset is driven by `~rst`.

## Timing
- Reset (synchronous, `rst`=1): `rr_ptr`=0, `sram_ena`=0, `sram_addr`=0, `sram_wdata`=0, tag pipe cleared, `rsp_valid`=0. `req_ready` is forced to 0 while `rst`=1.
- Read latency: handshake at edge T → `sram_addr` valid in cycle T+1 → SRAM samples at edge T+1 → `rsp_valid`/`rsp_data` valid in cycle T+2 (2 cycles).
- Write: handshake at edge T → `sram_ena`=1 in cycle T+1 → memory updated at edge T+1.
- Reset mid-operation: all in-flight reads are dropped, and no `rsp_valid` appears after the reset edge.
- Back-to-back reads from different requesters return data on consecutive cycles, each with the correct one-hot `rsp_valid`.

## Configuration
- `SRAM_ARB_STATS_EN` defined adds two outputs:
  - `stat_busy_cnt` [31:0]: cycles with any handshake.
  - `stat_conflict_cnt` [31:0]: cycles with more than one `req_valid` high.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- `SRAM_ARB_STATS_EN` undefined: the ports and counters are absent. Functional behaviour is identical either way.

## Structure
- Shared package/header `sram_arb_pkg`:
  - `MAX_REQ` = 8.
  - Tag width `TAG_W` = 1 + clog2(MAX_REQ).
  - Read latency constant `SRAM_RD_LAT` = 2.
- One sub-module `rr_arbiter`: parameterised NUM_REQ, inputs `req` and `ptr`, outputs one-hot `gnt` and index `gnt_idx`, purely combinational.
- The top holds `rr_ptr`, the command register, the tag pipe and the optional stats.

## Test plan
- Reset: assert `rst` 3 cycles with all `req_valid`=1 → `req_ready`=0, `sram_ena`=0, `rsp_valid`=0 throughout. After release, requester 0 is granted first.
- Write then read: req0 writes 0xDEADBEEF to addr 0x10, next cycle req1 reads 0x10 → `rsp_valid`=2'b10 exactly 2 cycles after the read handshake, `rsp_data`=0xDEADBEEF.
- Fairness: both requesters hold valid reads for 8 cycles → grants alternate 0,1,0,1… and each gets 4. With `SRAM_ARB_STATS_EN`, `stat_conflict_cnt`=8 and `stat_busy_cnt`=8.
- Streaming: req0 issues 16 back-to-back reads at addrs 0..15 of a preloaded SRAM → 16 consecutive `rsp_valid` cycles with data in address order, no bubbles.
- Reset mid-read: read accepted at cycle T, `rst`=1 at cycle T+1 → no `rsp_valid` at T+2, and `rr_ptr` returns to 0.
- Idle hold: no valid for 5 cycles → `sram_ena`=0, `sram_addr` unchanged, `rr_ptr` unchanged.
